video_timing_gen: RTL and testbench

//   Raster timing generator feeding the video output stage (video_main): walks the

---
 rtl/video_timing_gen.sv | 149 ++++++++++++++
 tb/tb_video_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the video output stage. Walks the pixel clock
// through the horizontal and vertical active / front-porch / sync / back-porch
// regions and emits pixel/line counters, a visible-area flag, line and frame
// strobes, and VGA sync. A copy of the sync pair is delayed by PIPE_DELAY
// clocks so it lines up with the colour pipeline.
//
// Ports
//   clk            in   pixel clock
//   rst_n          in   synchronous reset, active-low
//   h_count_o      out  pixel index in line, 0..H_TOTAL-1
//   v_count_o      out  line index in frame, 0..V_TOTAL-1
//   visible_o      out  high inside the active picture area
//   line_start_o   out  1-clk pulse when h_count_o == 0
//   frame_start_o  out  1-clk pulse when h_count_o == 0 and v_count_o == 0
//   hsync_o        out  undelayed hsync, aligned with h_count_o
//   vsync_o        out  undelayed vsync, aligned with v_count_o
//   vga_hsync_o    out  hsync_o delayed PIPE_DELAY clocks
//   vga_vsync_o    out  vsync_o delayed PIPE_DELAY clocks
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DELAY = 2,
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_count_o,
    output logic [VW-1:0] v_count_o,
    output logic          visible_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          vga_hsync_o,
    output logic          vga_vsync_o
);

    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        PIPE_DELAY > 7) begin : g_param_check
        $error("video_timing_gen: every region needs width >= 1 and PIPE_DELAY must be 0..7");
    end

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    // run_q stays low for the first edge after reset release so that (0,0)
    // is presented again, this time with its decoded flags asserted.
    logic          run_q;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_vis_next;
    logic          v_vis_next;
    logic          h_sync_next;
    logic          v_sync_next;

    always_comb begin
        h_next = '0;
        v_next = '0;
        if (run_q) begin
            if (h_count_o == H_LAST) begin
                h_next = '0;
                v_next = (v_count_o == V_LAST) ? '0 : v_count_o + 1'b1;
            end else begin
                h_next = h_count_o + 1'b1;
                v_next = v_count_o;
            end
        end
    end

    // Flags are decoded from the next-count values and registered together
    // with the counters, so every output describes the same (h,v).
    always_comb begin
        h_vis_next  = (h_next < H_VIS_END);
        v_vis_next  = (v_next < V_VIS_END);
        h_sync_next = (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
        v_sync_next = (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            h_count_o     <= '0;
            v_count_o     <= '0;
            visible_o     <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            hsync_o       <= ~H_SYNC_POL;
            vsync_o       <= ~V_SYNC_POL;
        end else begin
            run_q         <= 1'b1;
            h_count_o     <= h_next;
            v_count_o     <= v_next;
            visible_o     <= h_vis_next && v_vis_next;
            line_start_o  <= (h_next == '0);
            frame_start_o <= (h_next == '0) && (v_next == '0);
            hsync_o       <= h_sync_next ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_o       <= v_sync_next ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign vga_hsync_o = hsync_o;
        assign vga_vsync_o = vsync_o;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0] hs_pipe;
        logic [PIPE_DELAY-1:0] vs_pipe;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hs_pipe <= {PIPE_DELAY{~H_SYNC_POL}};
                vs_pipe <= {PIPE_DELAY{~V_SYNC_POL}};
            end else begin
                hs_pipe[0] <= hsync_o;
                vs_pipe[0] <= vsync_o;
                for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                    hs_pipe[i] <= hs_pipe[i-1];
                    vs_pipe[i] <= vs_pipe[i-1];
                end
            end
        end

        assign vga_hsync_o = hs_pipe[PIPE_DELAY-1];
        assign vga_vsync_o = vs_pipe[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Directed bench for video_timing_gen. One instance uses the default 640x480
// timing with PIPE_DELAY=2; a second, tiny instance (15x12 raster, active-high
// sync, PIPE_DELAY=0) makes whole-frame checks affordable.
//   small raster: H 8/2/3/2 -> hsync h=10..12, V 6/1/2/3 -> vsync v=7..8,
//   frame = 15*12 = 180 clocks, 8*6 = 48 visible pixels per frame.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_s_n;

    logic [9:0] h_def;
    logic [9:0] v_def;
    logic       vis_def, ls_def, fs_def, hs_def, vs_def, vga_hs_def, vga_vs_def;

    logic [3:0] h_s;
    logic [3:0] v_s;
    logic       vis_s, ls_s, fs_s, hs_s, vs_s, vga_hs_s, vga_vs_s;

    int n_checks = 0;
    int n_fail   = 0;
    int t_def    = -1;
    int t_s      = -1;

    always #5 clk = ~clk;

    video_timing_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_count_o     (h_def),
        .v_count_o     (v_def),
        .visible_o     (vis_def),
        .line_start_o  (ls_def),
        .frame_start_o (fs_def),
        .hsync_o       (hs_def),
        .vsync_o       (vs_def),
        .vga_hsync_o   (vga_hs_def),
        .vga_vsync_o   (vga_vs_def)
    );

    video_timing_gen #(
        .H_VISIBLE  (8),
        .H_FRONT    (2),
        .H_SYNC     (3),
        .H_BACK     (2),
        .V_VISIBLE  (6),
        .V_FRONT    (1),
        .V_SYNC     (2),
        .V_BACK     (3),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b1),
        .PIPE_DELAY (0)
    ) dut_s (
        .clk           (clk),
        .rst_n         (rst_s_n),
        .h_count_o     (h_s),
        .v_count_o     (v_s),
        .visible_o     (vis_s),
        .line_start_o  (ls_s),
        .frame_start_o (fs_s),
        .hsync_o       (hs_s),
        .vsync_o       (vs_s),
        .vga_hsync_o   (vga_hs_s),
        .vga_vsync_o   (vga_vs_s)
    );

    // Clocks elapsed since reset release; 0 is the first presented cycle.
    always @(posedge clk) begin
        if (!rst_n) t_def <= -1;
        else        t_def <= t_def + 1;
        if (!rst_s_n) t_s <= -1;
        else          t_s <= t_s + 1;
    end

    // Reference values for the default 800x525 raster at clock index t.
    function automatic logic [9:0] def_h(input int t);
        return 10'(t % 800);
    endfunction
    function automatic logic [9:0] def_v(input int t);
        return 10'((t / 800) % 525);
    endfunction
    function automatic logic def_hs(input int t);
        int h;
        if (t < 0) return 1'b1;
        h = t % 800;
        return !(h >= 656 && h <= 751);
    endfunction
    function automatic logic def_vs(input int t);
        int v;
        if (t < 0) return 1'b1;
        v = (t / 800) % 525;
        return !(v >= 490 && v <= 491);
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (h_def !== 10'd0 || v_def !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_counts: h=%0d v=%0d expected h=0 v=0", h_def, v_def);
        end
        n_checks++;
        if ({vis_def, ls_def, fs_def} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: vis/ls/fs=%b expected 000", {vis_def, ls_def, fs_def});
        end
        n_checks++;
        if ({hs_def, vs_def, vga_hs_def, vga_vs_def} !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_sync: hs/vs/vga_hs/vga_vs=%b expected 1111",
                     {hs_def, vs_def, vga_hs_def, vga_vs_def});
        end
        n_checks++;
        if ({h_s, v_s, vis_s, ls_s, fs_s, hs_s, vs_s, vga_hs_s, vga_vs_s} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_small: h=%0d v=%0d flags=%b expected all zero (active-high sync)",
                     h_s, v_s, {vis_s, ls_s, fs_s, hs_s, vs_s, vga_hs_s, vga_vs_s});
        end
    endtask

    // Two full frames plus one cycle of the small raster.
    task automatic test_small_frame();
        int t, h, v, n_fs, n_vis, n_vs;
        logic e_vis, e_hs, e_vs;
        n_fs = 0; n_vis = 0; n_vs = 0;
        rst_s_n = 1'b1;
        for (int i = 0; i <= 360; i++) begin
            @(negedge clk);
            t = t_s;
            h = t % 15;
            v = (t / 15) % 12;
            e_vis = (h < 8) && (v < 6);
            e_hs  = (h >= 10) && (h <= 12);
            e_vs  = (v >= 7) && (v <= 8);
            n_checks++;
            if (h_s !== 4'(h) || v_s !== 4'(v)) begin
                n_fail++;
                $display("FAIL small_count t=%0d: h=%0d v=%0d expected h=%0d v=%0d", t, h_s, v_s, h, v);
            end
            n_checks++;
            if ({vis_s, ls_s, fs_s} !== {e_vis, h == 0, h == 0 && v == 0}) begin
                n_fail++;
                $display("FAIL small_flags t=%0d: vis/ls/fs=%b expected %b", t,
                         {vis_s, ls_s, fs_s}, {e_vis, h == 0, h == 0 && v == 0});
            end
            n_checks++;
            if ({hs_s, vs_s, vga_hs_s, vga_vs_s} !== {e_hs, e_vs, e_hs, e_vs}) begin
                n_fail++;
                $display("FAIL small_sync t=%0d: hs/vs/vga_hs/vga_vs=%b expected %b", t,
                         {hs_s, vs_s, vga_hs_s, vga_vs_s}, {e_hs, e_vs, e_hs, e_vs});
            end
            if (fs_s === 1'b1) n_fs++;
            if (t < 180 && vis_s === 1'b1) n_vis++;
            if (t < 180 && vs_s === 1'b1) n_vs++;
        end
        n_checks++;
        if (n_fs !== 3) begin
            n_fail++;
            $display("FAIL small_frame_starts: got %0d expected 3 (t=0,180,360)", n_fs);
        end
        n_checks++;
        if (n_vis !== 48) begin
            n_fail++;
            $display("FAIL small_visible_per_frame: got %0d expected 48", n_vis);
        end
        n_checks++;
        if (n_vs !== 30) begin
            n_fail++;
            $display("FAIL small_vsync_clocks: got %0d expected 30", n_vs);
        end
    endtask

    // Release the default instance and follow it across two line wraps.
    task automatic test_line_start();
        int t, n_ls;
        n_ls = 0;
        rst_n = 1'b1;
        for (int i = 0; i <= 1600; i++) begin
            @(negedge clk);
            t = t_def;
            if (i == 0) begin
                n_checks++;
                if ({h_def, v_def, vis_def, ls_def, fs_def} !== {10'd0, 10'd0, 3'b111}) begin
                    n_fail++;
                    $display("FAIL first_cycle: h=%0d v=%0d vis/ls/fs=%b expected 0 0 111",
                             h_def, v_def, {vis_def, ls_def, fs_def});
                end
            end
            if (t == 799) begin
                n_checks++;
                if (h_def !== 10'd799 || v_def !== 10'd0) begin
                    n_fail++;
                    $display("FAIL h_last: h=%0d v=%0d expected 799 0", h_def, v_def);
                end
            end
            n_checks++;
            if (h_def !== def_h(t) || v_def !== def_v(t) || ls_def !== (t % 800 == 0)) begin
                n_fail++;
                $display("FAIL line_walk t=%0d: h=%0d v=%0d ls=%b expected %0d %0d %b",
                         t, h_def, v_def, ls_def, def_h(t), def_v(t), t % 800 == 0);
            end
            if (ls_def === 1'b1) n_ls++;
        end
        n_checks++;
        if (n_ls !== 3) begin
            n_fail++;
            $display("FAIL line_start_pulses: got %0d expected 3 (t=0,800,1600)", n_ls);
        end
    endtask

    task automatic test_hsync();
        int t, n_low;
        n_low = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            t = t_def;
            n_checks++;
            if (hs_def !== def_hs(t)) begin
                n_fail++;
                $display("FAIL hsync h=%0d: got %b expected %b", def_h(t), hs_def, def_hs(t));
            end
            if (hs_def === 1'b0) n_low++;
        end
        n_checks++;
        if (n_low !== 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected 96", n_low);
        end
    endtask

    task automatic test_visible();
        int t, n_vis;
        n_vis = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            t = t_def;
            n_checks++;
            if (vis_def !== (def_h(t) < 10'd640)) begin
                n_fail++;
                $display("FAIL visible h=%0d v=%0d: got %b expected %b",
                         def_h(t), def_v(t), vis_def, def_h(t) < 10'd640);
            end
            if (vis_def === 1'b1) n_vis++;
        end
        n_checks++;
        if (n_vis !== 640) begin
            n_fail++;
            $display("FAIL visible_per_line: got %0d expected 640", n_vis);
        end
    endtask

    task automatic test_pipe_delay();
        int t;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            t = t_def;
            n_checks++;
            if (vga_hs_def !== def_hs(t - 2) || vga_vs_def !== def_vs(t - 2)) begin
                n_fail++;
                $display("FAIL pipe_delay t=%0d: vga_hs=%b vga_vs=%b expected %b %b",
                         t, vga_hs_def, vga_vs_def, def_hs(t - 2), def_vs(t - 2));
            end
        end
    endtask

    // Reset pulse inside hsync (h=700, v=5) so the delay stages hold active
    // values when the reset edge arrives.
    task automatic test_reset_mid_frame();
        int t;
        bit found;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (t_def == 5 * 800 + 700) found = 1;
        end
        n_checks++;
        if (!found || h_def !== 10'd700 || v_def !== 10'd5 || vga_hs_def !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_position: found=%0d h=%0d v=%0d vga_hs=%b expected 1 700 5 0",
                     found, h_def, v_def, vga_hs_def);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({h_def, v_def} !== 20'd0 || {vis_def, ls_def, fs_def} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_state: h=%0d v=%0d vis/ls/fs=%b expected 0 0 000",
                     h_def, v_def, {vis_def, ls_def, fs_def});
        end
        n_checks++;
        if ({hs_def, vs_def, vga_hs_def, vga_vs_def} !== 4'b1111) begin
            n_fail++;
            $display("FAIL mid_reset_sync: hs/vs/vga_hs/vga_vs=%b expected 1111",
                     {hs_def, vs_def, vga_hs_def, vga_vs_def});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            t = t_def;
            n_checks++;
            if (h_def !== 10'(i) || v_def !== 10'd0 || fs_def !== (i == 0) || vga_hs_def !== 1'b1) begin
                n_fail++;
                $display("FAIL restart i=%0d: h=%0d v=%0d fs=%b vga_hs=%b expected %0d 0 %b 1",
                         i, h_def, v_def, fs_def, vga_hs_def, i, i == 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_frame();
        test_line_start();
        test_hsync();
        test_visible();
        test_pipe_delay();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
